// File: rtl/app_cmd_sequencer.sv
// Burst command sequencer: queues {cmd, bl, addr} burst requests and expands each
// into bl native commands on the app_* interface, tracking outstanding read beats.
module app_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_STEP  = 8
) (
    input  logic        I_clk,
    input  logic        I_Rst_n,
    input  logic        cmd_wren,
    input  logic [2:0]  cmd_wrcmd,
    input  logic [7:0]  cmd_wrbl,
    input  logic [27:0] cmd_wraddr,
    output logic        cmd_full,
    output logic        cmd_overflow,
    output logic        app_en,
    output logic [2:0]  app_cmd,
    output logic [27:0] app_addr,
    input  logic        app_rdy,
    input  logic        app_rd_data_valid,
    output logic        cmd_done,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // app_en/app_rdy: a native command transfers on every rising edge where both are 1;
    // app_cmd/app_addr are held unchanged while app_en=1 and app_rdy=0.

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [38:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [2:0]    cur_cmd;
    logic [27:0]   cur_addr;
    logic [7:0]    remaining;
    logic [15:0]   rd_pending;
    logic          push, pop, accept, rd_acc;
    logic [38:0]   head;

    assign cmd_full = (count == CW'(FIFO_DEPTH));
    assign push     = cmd_wren & ~cmd_full;
    assign pop      = (state == S_IDLE) & (count != '0);
    assign head     = mem[rd_ptr];
    assign accept   = app_en & app_rdy;
    assign rd_acc   = accept & (cur_cmd == 3'b001);
    assign busy     = (state != S_IDLE) | (count != '0) | (rd_pending != 16'd0);

    always_ff @(posedge I_clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_wrcmd, cmd_wrbl, cmd_wraddr};
        end
    end

    always_ff @(posedge I_clk) begin
        if (!I_Rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            cmd_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (cmd_wren & cmd_full) cmd_overflow <= 1'b1;
        end
    end

    // State register
    always_ff @(posedge I_clk) begin
        if (!I_Rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; a zero-length entry is popped and dropped without leaving IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pop && head[35:28] != 8'd0) state_nxt = S_ISSUE;
            S_ISSUE: if (app_rdy && remaining == 8'd1) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        app_en    = 1'b0;
        cmd_done  = 1'b0;
        app_cmd   = cur_cmd;
        app_addr  = cur_addr;
        dbg_state = state;
        case (state)
            S_ISSUE: app_en   = 1'b1;
            S_DONE:  cmd_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (!I_Rst_n) begin
            cur_cmd   <= 3'd0;
            cur_addr  <= 28'd0;
            remaining <= 8'd0;
        end else if (pop) begin
            cur_cmd   <= head[38:36];
            remaining <= head[35:28];
            cur_addr  <= head[27:0];
        end else if (accept) begin
            cur_addr  <= cur_addr + 28'(ADDR_STEP);
            remaining <= remaining - 8'd1;
        end
    end

    always_ff @(posedge I_clk) begin
        if (!I_Rst_n) begin
            rd_pending <= 16'd0;
        end else if (rd_acc && !app_rd_data_valid) begin
            if (rd_pending != 16'hFFFF) rd_pending <= rd_pending + 16'd1;
        end else if (!rd_acc && app_rd_data_valid) begin
            if (rd_pending != 16'd0) rd_pending <= rd_pending - 16'd1;
        end
    end

endmodule
